// File: rtl/rep_add_multiplier.sv
// rep_add_multiplier
// Unsigned multiplier built from repeated addition. A small FSM sequences a
// 2*WIDTH accumulator that adds the addend once per cycle until the iteration
// counter reaches zero, then latches the sum into a held product register.
// With SWAP_MIN set, the smaller operand becomes the iteration count so the
// operation finishes in fewer cycles.
module rep_add_multiplier #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned SWAP_MIN = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [WIDTH-1:0]   a_in,
  input  logic [WIDTH-1:0]   b_in,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

  state_t               state;
  state_t               state_nxt;
  logic [WIDTH-1:0]     opa;
  logic [WIDTH-1:0]     cnt;
  logic [2*WIDTH-1:0]   acc;
  logic                 swap;
  logic                 cnt_zero;

  assign swap     = (SWAP_MIN != 0) && (a_in < b_in);
  assign cnt_zero = (cnt == '0);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: abort outranks completion, which outranks another add.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = CALC;
        end
      end
      CALC: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (cnt_zero) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Datapath: operand capture on accept, one add per CALC cycle, product latch on finish.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      opa     <= '0;
      cnt     <= '0;
      product <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            acc <= '0;
            if (swap) begin
              opa <= b_in;
              cnt <= a_in;
            end else begin
              opa <= a_in;
              cnt <= b_in;
            end
          end
        end
        CALC: begin
          if (!abort) begin
            if (cnt_zero) begin
              product <= acc;
            end else begin
              acc <= acc + {{WIDTH{1'b0}}, opa};
              cnt <= cnt - CNT_ONE;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_rep_add_multiplier.sv
// tb_rep_add_multiplier
// Drives two multipliers side by side (iterate-on-min and iterate-on-b) with
// shared inputs, and compares products, completion latency, busy/done shape,
// abort, reset and back-to-back behaviour against plain arithmetic.
module tb_rep_add_multiplier;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [7:0]  a_in;
  logic [7:0]  b_in;
  logic        busy1, done1;
  logic [15:0] prod1;
  logic        busy0, done0;
  logic [15:0] prod0;

  int vectors;
  int miscompares;
  int cyc;
  int e0;
  logic [15:0] exp_last1;
  logic [15:0] exp_last0;
  logic [15:0] q1[$];
  logic [15:0] q0[$];

  rep_add_multiplier #(.WIDTH(8), .SWAP_MIN(1)) u_dut_min (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .a_in(a_in), .b_in(b_in), .busy(busy1), .done(done1), .product(prod1)
  );

  rep_add_multiplier #(.WIDTH(8), .SWAP_MIN(0)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .a_in(a_in), .b_in(b_in), .busy(busy0), .done(done0), .product(prod0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One operation on both DUTs; waits until both have completed and settled.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input bit with_abort);
    int n1, n0, lat1, lat0, dcnt1, dcnt0, t;
    bit got1, got0, gap1, gap0;
    logic [15:0] p1, p0, expp;
    n1 = (a < b) ? int'(a) : int'(b);
    n0 = int'(b);
    expp = 16'(a) * 16'(b);
    lat1 = -1; lat0 = -1; dcnt1 = 0; dcnt0 = 0;
    got1 = 0; got0 = 0; gap1 = 0; gap0 = 0;
    p1 = '0; p0 = '0;
    @(negedge clk);
    a_in = a; b_in = b; start = 1'b1; abort = with_abort;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    a_in = 8'($urandom); b_in = 8'($urandom);
    e0 = cyc;
    t = 0;
    while (t <= 600) begin
      if (done1) begin
        dcnt1++;
        if (!got1) begin got1 = 1; lat1 = t; p1 = prod1; end
      end else if (!got1 && !busy1) gap1 = 1;
      if (done0) begin
        dcnt0++;
        if (!got0) begin got0 = 1; lat0 = t; p0 = prod0; end
      end else if (!got0 && !busy0) gap0 = 1;
      if (got1 && got0 && t >= lat1 + 2 && t >= lat0 + 2) break;
      @(negedge clk);
      t = cyc - e0;
    end
    check("min_done_seen", 32'(got1), 32'd1);
    check("b_done_seen",   32'(got0), 32'd1);
    check("min_latency",   32'(lat1), 32'(n1 + 1));
    check("b_latency",     32'(lat0), 32'(n0 + 1));
    check("min_product",   32'(p1), 32'(expp));
    check("b_product",     32'(p0), 32'(expp));
    check("min_done_width", 32'(dcnt1), 32'd1);
    check("b_done_width",   32'(dcnt0), 32'd1);
    check("min_busy_gap",  32'(gap1), 32'd0);
    check("b_busy_gap",    32'(gap0), 32'd0);
    check("min_idle_after", 32'(busy1), 32'd0);
    check("b_idle_after",   32'(busy0), 32'd0);
    check("min_product_held", 32'(prod1), 32'(expp));
    check("b_product_held",   32'(prod0), 32'(expp));
    exp_last1 = expp;
    exp_last0 = expp;
  endtask

  // Compare one DUT's completion against its queue of accepted operations.
  task automatic b2b_observe(input string tag, input logic dn, input logic [15:0] pr,
                             inout logic [15:0] q[$], inout logic [15:0] last);
    if (dn) begin
      if (q.size() == 0) begin
        check({tag, "_unexpected_done"}, 32'(q.size()), 32'd1);
      end else begin
        last = q.pop_front();
        check({tag, "_product"}, 32'(pr), 32'(last));
      end
    end else begin
      check({tag, "_hold"}, 32'(pr), 32'(last));
    end
  endtask

  initial begin
    bit seen;
    logic [7:0] ra, rb;
    vectors = 0; miscompares = 0; cyc = 0; e0 = 0;
    exp_last1 = '0; exp_last0 = '0;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; a_in = '0; b_in = '0;

    #3;
    check("rst_busy_min", 32'(busy1), 32'd0);
    check("rst_done_min", 32'(done1), 32'd0);
    check("rst_prod_min", 32'(prod1), 32'd0);
    check("rst_prod_b",   32'(prod0), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Directed operations, including zero operands, equal operands, max values.
    run_op(8'd3,   8'd5,   1'b0);
    run_op(8'd0,   8'd200, 1'b0);
    run_op(8'd255, 8'd255, 1'b0);
    run_op(8'd200, 8'd0,   1'b0);
    run_op(8'd9,   8'd9,   1'b0);
    // start and abort together while idle: start must win.
    run_op(8'd4,   8'd250, 1'b1);

    // Abort mid-operation; a start pulse while busy must be ignored.
    run_op(8'd10, 8'd20, 1'b0);
    @(negedge clk);
    a_in = 8'd12; b_in = 8'd13; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen = 0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      seen = seen | done1 | done0;
      if (k == 2) begin a_in = 8'd1; b_in = 8'd1; start = 1'b1; end
      if (k == 3) start = 1'b0;
      if (k == 4) abort = 1'b1;
      if (k == 5) abort = 1'b0;
    end
    check("abort_busy_min", 32'(busy1), 32'd0);
    check("abort_busy_b",   32'(busy0), 32'd0);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      seen = seen | done1 | done0 | busy1 | busy0;
    end
    check("abort_no_done",  32'(seen), 32'd0);
    check("abort_prod_min", 32'(prod1), 32'd200);
    check("abort_prod_b",   32'(prod0), 32'd200);

    // Asynchronous reset in the middle of a calculation.
    @(negedge clk);
    a_in = 8'd200; b_in = 8'd150; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy_min", 32'(busy1), 32'd0);
    check("arst_busy_b",   32'(busy0), 32'd0);
    check("arst_done_min", 32'(done1), 32'd0);
    check("arst_prod_min", 32'(prod1), 32'd0);
    check("arst_prod_b",   32'(prod0), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_last1 = '0; exp_last0 = '0;
    run_op(8'd7, 8'd6, 1'b0);

    // Randomized single operations.
    for (int i = 0; i < 12; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      if (i == 3) ra = rb;
      run_op(ra, rb, 1'b0);
    end

    // Back-to-back with start held high and operands changing every cycle.
    @(negedge clk);
    start = 1'b1;
    for (int c = 0; c < 300; c++) begin
      b2b_observe("b2b_min", done1, prod1, q1, exp_last1);
      b2b_observe("b2b_b",   done0, prod0, q0, exp_last0);
      ra = 8'($urandom_range(0, 15));
      rb = 8'($urandom_range(0, 15));
      if (!busy1) q1.push_back(16'(ra) * 16'(rb));
      if (!busy0) q0.push_back(16'(ra) * 16'(rb));
      a_in = ra; b_in = rb;
      @(negedge clk);
    end
    start = 1'b0;
    for (int c = 0; c < 600; c++) begin
      if (q1.size() == 0 && q0.size() == 0) break;
      b2b_observe("drain_min", done1, prod1, q1, exp_last1);
      b2b_observe("drain_b",   done0, prod0, q0, exp_last0);
      @(negedge clk);
    end
    check("drain_left_min", 32'(q1.size()), 32'd0);
    check("drain_left_b",   32'(q0.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
